// File: rtl/data_pack_hcp.sv
// Packs a 9-bit GMII byte stream (bit8 marks head/tail) into left-aligned 64-bit words,
// tracking packet length, receive timestamp and length errors on the tail word.
module data_pack_hcp (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  input  logic [18:0] iv_rec_ts,
  output logic [63:0] ov_data,
  output logic        o_data_wr,
  output logic        o_head,
  output logic        o_tail,
  output logic [3:0]  ov_word_bytes,
  output logic [11:0] ov_pkt_len,
  output logic [18:0] ov_rec_ts,
  output logic        o_len_error,
  output logic        o_pkt_pulse,
  output logic        o_err_pulse,
  output logic [1:0]  report_pack_state
);

  localparam logic [11:0] MinLen = 12'd64;
  localparam logic [11:0] MaxLen = 12'd1518;
  localparam logic [11:0] CapLen = 12'd2048;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPack    = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] acc_q;
  logic [2:0]  lane_q;
  logic [11:0] len_q;
  logic [18:0] ts_q;
  logic        head_q;

  logic [63:0] word_d;
  logic [11:0] len_d;
  logic [3:0]  bytes_d;
  logic        len_bad;
  logic        emit;

  always_comb begin
    // Current byte merged into the lane selected by lane_q; lane 0 is the MSB byte.
    word_d  = acc_q | ({iv_data[7:0], 56'd0} >> {lane_q, 3'd0});
    len_d   = len_q + 12'd1;
    bytes_d = {1'b0, lane_q} + 4'd1;
    len_bad = (len_d < MinLen) || (len_d > MaxLen);
    emit    = iv_data[8] || (lane_q == 3'd7) || (len_d == CapLen);
  end

  assign report_pack_state = state_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      lane_q        <= '0;
      len_q         <= '0;
      ts_q          <= '0;
      head_q        <= 1'b0;
      ov_data       <= '0;
      o_data_wr     <= 1'b0;
      o_head        <= 1'b0;
      o_tail        <= 1'b0;
      ov_word_bytes <= '0;
      ov_pkt_len    <= '0;
      ov_rec_ts     <= '0;
      o_len_error   <= 1'b0;
      o_pkt_pulse   <= 1'b0;
      o_err_pulse   <= 1'b0;
    end else begin
      // Outputs are strobes: cleared every cycle unless a word is emitted.
      ov_data       <= '0;
      o_data_wr     <= 1'b0;
      o_head        <= 1'b0;
      o_tail        <= 1'b0;
      ov_word_bytes <= '0;
      ov_pkt_len    <= '0;
      ov_rec_ts     <= '0;
      o_len_error   <= 1'b0;
      o_pkt_pulse   <= 1'b0;
      o_err_pulse   <= 1'b0;

      case (state_q)
        StIdle: begin
          if (i_data_wr && iv_data[8]) begin
            acc_q   <= {iv_data[7:0], 56'd0};
            lane_q  <= 3'd1;
            len_q   <= 12'd1;
            ts_q    <= iv_rec_ts;
            head_q  <= 1'b1;
            state_q <= StPack;
          end
        end

        StPack: begin
          if (i_data_wr) begin
            acc_q  <= word_d;
            lane_q <= lane_q + 3'd1;
            len_q  <= len_d;
            if (emit) begin
              ov_data       <= word_d;
              o_data_wr     <= 1'b1;
              ov_word_bytes <= bytes_d;
              o_head        <= head_q;
              head_q        <= 1'b0;
              acc_q         <= '0;
              lane_q        <= '0;
              if (iv_data[8]) begin
                o_tail      <= 1'b1;
                ov_pkt_len  <= len_d;
                ov_rec_ts   <= ts_q;
                o_len_error <= len_bad;
                o_pkt_pulse <= !len_bad;
                o_err_pulse <= len_bad;
                len_q       <= '0;
                state_q     <= StIdle;
              end else if (len_d == CapLen) begin
                // Overlong: close the packet here and swallow the rest up to its tail.
                o_tail      <= 1'b1;
                ov_pkt_len  <= len_d;
                ov_rec_ts   <= ts_q;
                o_len_error <= 1'b1;
                o_err_pulse <= 1'b1;
                len_q       <= '0;
                state_q     <= StDiscard;
              end
            end
          end
        end

        StDiscard: begin
          if (i_data_wr && iv_data[8]) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_pack_hcp.sv
// Scoreboard bench for data_pack_hcp: the driver queues expected words as bytes are issued,
// a negedge monitor pops and compares each emitted word and checks idle outputs are zero.
module tb_data_pack_hcp;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [8:0]  iv_data = '0;
  logic        i_data_wr = 1'b0;
  logic [18:0] iv_rec_ts = '0;
  logic [63:0] ov_data;
  logic        o_data_wr;
  logic        o_head;
  logic        o_tail;
  logic [3:0]  ov_word_bytes;
  logic [11:0] ov_pkt_len;
  logic [18:0] ov_rec_ts;
  logic        o_len_error;
  logic        o_pkt_pulse;
  logic        o_err_pulse;
  logic [1:0]  report_pack_state;

  data_pack_hcp dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .iv_data           (iv_data),
    .i_data_wr         (i_data_wr),
    .iv_rec_ts         (iv_rec_ts),
    .ov_data           (ov_data),
    .o_data_wr         (o_data_wr),
    .o_head            (o_head),
    .o_tail            (o_tail),
    .ov_word_bytes     (ov_word_bytes),
    .ov_pkt_len        (ov_pkt_len),
    .ov_rec_ts         (ov_rec_ts),
    .o_len_error       (o_len_error),
    .o_pkt_pulse       (o_pkt_pulse),
    .o_err_pulse       (o_err_pulse),
    .report_pack_state (report_pack_state)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  nb;
    logic        head;
    logic        tail;
    logic        err;
    logic [11:0] len;
    logic [18:0] ts;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   words = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (mon_en) begin
      if (o_data_wr) begin
        words++;
        if (sb.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc), 64'(e.cyc));
          check("data", ov_data, e.data);
          check("word_bytes", 64'(ov_word_bytes), 64'(e.nb));
          check("head_tail", {62'd0, o_head, o_tail}, {62'd0, e.head, e.tail});
          check("pkt_len", 64'(ov_pkt_len), 64'(e.len));
          check("rec_ts", 64'(ov_rec_ts), 64'(e.ts));
          check("len_error", 64'(o_len_error), 64'(e.err));
          check("pulses", {62'd0, o_pkt_pulse, o_err_pulse},
                {62'd0, e.tail && !e.err, e.tail && e.err});
        end
      end else begin
        check("idle_outputs_zero",
              64'(|{ov_data, o_head, o_tail, ov_word_bytes, ov_pkt_len, ov_rec_ts,
                    o_len_error, o_pkt_pulse, o_err_pulse}), 64'd0);
      end
    end
  end

  task automatic drive(input logic [8:0] d, input logic [18:0] ts);
    @(negedge clk_sys);
    iv_data   = d;
    i_data_wr = 1'b1;
    iv_rec_ts = ts;
  endtask

  // Junk on the data lines while not valid must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      i_data_wr = 1'b0;
      iv_data   = 9'($urandom);
      iv_rec_ts = 19'($urandom);
    end
  endtask

  // Sends one packet; exp_err/exp_len are the hand-derived tail-word values.
  task automatic send_pkt(input int len, input logic [18:0] ts, input int max_gap,
                          input logic exp_err, input int exp_len, input int seed);
    logic [63:0] acc;
    int          lane;
    int          n;
    bit          disc;
    bit          first;
    logic        tl;
    logic [7:0]  b;
    exp_t        e;
    acc = '0; lane = 0; n = 0; disc = 0; first = 1;
    for (int i = 0; i < len; i++) begin
      if (max_gap > 0 && i > 0) idle(int'($urandom_range(0, max_gap)));
      b  = 8'(i * 7 + seed);
      tl = (i == len - 1);
      drive({(i == 0) || tl, b}, (i == 0) ? ts : 19'($urandom));
      if (!disc) begin
        acc[63 - 8 * lane -: 8] = b;
        lane++;
        n++;
        if (tl || lane == 8 || n == 2048) begin
          e.data = acc;
          e.nb   = 4'(lane);
          e.head = first;
          e.tail = tl || (n == 2048);
          e.err  = e.tail ? exp_err : 1'b0;
          e.len  = e.tail ? 12'(exp_len) : 12'd0;
          e.ts   = e.tail ? ts : 19'd0;
          e.cyc  = cyc + 1;
          sb.push_back(e);
          first = 0;
          acc   = '0;
          lane  = 0;
          disc  = (n == 2048) && !tl;
        end
      end
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk_sys);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    mon_en = 1'b1;
    idle(3);
    check("reset_state", 64'(report_pack_state), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // 64-byte good packet, contiguous
    send_pkt(64, 19'h12345, 0, 1'b0, 64, 3);
    idle(4);
    // 61-byte runt with gaps
    send_pkt(61, 19'h00abc, 3, 1'b1, 61, 11);
    idle(4);
    // 2-byte packet: single head+tail word
    send_pkt(2, 19'h7ffff, 0, 1'b1, 2, 40);
    idle(4);
    // Overlong: capped at 2048, remaining 52 bytes dropped
    send_pkt(2100, 19'h00001, 0, 1'b1, 2048, 5);
    idle(3);
    check("state_after_overlong", 64'(report_pack_state), 64'd0);
    send_pkt(64, 19'h02222, 0, 1'b0, 64, 9);
    idle(4);
    // Max-length then min-length, head directly after tail
    send_pkt(1518, 19'h33333, 0, 1'b0, 1518, 1);
    send_pkt(64, 19'h44444, 0, 1'b0, 64, 2);
    idle(4);

    // Stray middle bytes in idle are dropped
    repeat (3) drive({1'b0, 8'h55}, 19'h1);
    idle(2);
    check("state_after_stray", 64'(report_pack_state), 64'd0);
    // Partial packet abandoned by reset
    drive({1'b1, 8'ha0}, 19'h5);
    for (int i = 0; i < 5; i++) drive({1'b0, 8'(i)}, 19'h0);
    idle(1);
    check("state_mid_packet", 64'(report_pack_state), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_clears_state", 64'(report_pack_state), 64'd0);
    idle(3);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive({1'b0, 8'(8'h30 + i)}, 19'h0);
    idle(2);
    check("state_after_release", 64'(report_pack_state), 64'd0);
    send_pkt(64, 19'h55555, 0, 1'b0, 64, 77);
    idle(5);

    check("queue_empty", 64'(sb.size()), 64'd0);
    // 8+8+1+256+8+190+8+8
    check("word_count", 64'(words), 64'd487);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
